// File: rtl/desalojo_pkg.sv
// Shared types and constants for the desalojo_lru victim selector.
package desalojo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int MODE_LRU  = 0;
  localparam int MODE_FIFO = 1;

endpackage

// File: rtl/desalojo_age_update.sv
// Promotes one way of a set to MRU; every way younger than its old age ages by one.
module desalojo_age_update
  import desalojo_pkg::*;
#(
  parameter  int WAYS  = 4,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-1:0][WAY_W-1:0] age,
  input  logic [WAY_W-1:0]           way,
  output logic [WAYS-1:0][WAY_W-1:0] age_new
);

  logic [WAY_W-1:0] old_age;

  assign old_age = age[way];

  for (genvar i = 0; i < WAYS; i++) begin : g_way
    assign age_new[i] = (WAY_W'(i) == way) ? '0 :
                        (age[i] < old_age) ? age[i] + WAY_W'(1) : age[i];
  end

endmodule

// File: rtl/desalojo_lru.sv
// Per-set victim selector (true LRU or FIFO) with request/offer handshake.
module desalojo_lru
  import desalojo_pkg::*;
#(
  parameter  int WAYS  = 4,
  parameter  int SETS  = 16,
  parameter  int MODE  = MODE_LRU,
  localparam int WAY_W = $clog2(WAYS),
  localparam int SET_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acc_valid,
  input  logic [SET_W-1:0] acc_set,
  input  logic [WAY_W-1:0] acc_way,
  input  logic             inv_valid,
  input  logic [SET_W-1:0] inv_set,
  input  logic [WAY_W-1:0] inv_way,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [SET_W-1:0] req_set,
  output logic             vic_valid,
  output logic [WAY_W-1:0] vic_way,
  output logic             vic_empty,
  input  logic             vic_ready
);

  logic [WAYS-1:0]            set_valid [SETS];
  logic [WAYS-1:0][WAY_W-1:0] set_age   [SETS];
  logic [WAY_W-1:0]           set_ptr   [SETS];

  state_t           state;
  logic [SET_W-1:0] set_q;
  logic             settle;

  logic [WAYS-1:0]            q_valid;
  logic [WAYS-1:0][WAY_W-1:0] q_age;
  logic [WAY_W-1:0]           q_ptr;
  logic [WAY_W-1:0]           sel_way;
  logic                       sel_empty;
  logic                       commit;
  logic [WAYS-1:0][WAY_W-1:0] age_commit;
  logic [WAYS-1:0][WAY_W-1:0] age_acc;
  logic [WAYS-1:0]            acc_line_valid;

  assign q_valid        = set_valid[set_q];
  assign q_age          = set_age[set_q];
  assign q_ptr          = set_ptr[set_q];
  assign commit         = (state == RESP) && vic_ready;
  assign acc_line_valid = set_valid[acc_set];

  // Lowest invalid way wins; otherwise the policy picks among full ways.
  always_comb begin
    sel_way   = '0;
    sel_empty = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!q_valid[WAY_W'(w)]) begin
        sel_way   = WAY_W'(w);
        sel_empty = 1'b1;
      end
    end
    if (!sel_empty) begin
      if (MODE == MODE_FIFO) begin
        sel_way = q_ptr;
      end else begin
        for (int w = 0; w < WAYS; w++) begin
          if (q_age[WAY_W'(w)] == WAY_W'(WAYS - 1)) sel_way = WAY_W'(w);
        end
      end
    end
  end

  desalojo_age_update #(.WAYS(WAYS)) u_age_commit (
    .age     (q_age),
    .way     (vic_way),
    .age_new (age_commit)
  );

  desalojo_age_update #(.WAYS(WAYS)) u_age_acc (
    .age     (set_age[acc_set]),
    .way     (acc_way),
    .age_new (age_acc)
  );

  // LOOKUP spends one settle cycle before registering the victim, so the
  // offer appears two edges after acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      vic_valid <= 1'b0;
      vic_way   <= '0;
      vic_empty <= 1'b0;
      set_q     <= '0;
      settle    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            set_q     <= req_set;
            settle    <= 1'b1;
            req_ready <= 1'b0;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (settle) begin
            settle <= 1'b0;
          end else begin
            vic_way   <= sel_way;
            vic_empty <= sel_empty;
            vic_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (vic_ready) begin
            vic_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Per-set update: inv beats commit beats acc within one set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        set_valid[SET_W'(s)] <= '0;
        set_ptr[SET_W'(s)]   <= '0;
        for (int w = 0; w < WAYS; w++) set_age[SET_W'(s)][WAY_W'(w)] <= WAY_W'(w);
      end
    end else begin
      for (int s = 0; s < SETS; s++) begin
        if (inv_valid && inv_set == SET_W'(s)) begin
          set_valid[SET_W'(s)][inv_way] <= 1'b0;
        end else if (commit && set_q == SET_W'(s)) begin
          set_valid[SET_W'(s)][vic_way] <= 1'b1;
          set_age[SET_W'(s)]            <= age_commit;
          if (MODE == MODE_FIFO && !vic_empty)
            set_ptr[SET_W'(s)] <= set_ptr[SET_W'(s)] + WAY_W'(1);
        end else if (acc_valid && acc_set == SET_W'(s) && acc_line_valid[acc_way]) begin
          set_age[SET_W'(s)] <= age_acc;
        end
      end
    end
  end

endmodule

// File: tb/tb_desalojo_lru.sv
// Directed bench: an LRU and a FIFO instance share stimulus; expectations are hand-derived.
module tb_desalojo_lru;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       acc_valid = 1'b0, inv_valid = 1'b0, req_valid = 1'b0, vic_ready = 1'b0;
  logic [3:0] acc_set = '0, inv_set = '0, req_set = '0;
  logic [1:0] acc_way = '0, inv_way = '0;

  logic       req_ready0, vic_valid0, vic_empty0;
  logic       req_ready1, vic_valid1, vic_empty1;
  logic [1:0] vic_way0, vic_way1;

  int cmp = 0;
  int err = 0;

  always #5 clk = ~clk;

  desalojo_lru #(.WAYS(4), .SETS(16), .MODE(0)) dut0 (
    .clk(clk), .rst(rst),
    .acc_valid(acc_valid), .acc_set(acc_set), .acc_way(acc_way),
    .inv_valid(inv_valid), .inv_set(inv_set), .inv_way(inv_way),
    .req_valid(req_valid), .req_ready(req_ready0), .req_set(req_set),
    .vic_valid(vic_valid0), .vic_way(vic_way0), .vic_empty(vic_empty0),
    .vic_ready(vic_ready)
  );

  desalojo_lru #(.WAYS(4), .SETS(16), .MODE(1)) dut1 (
    .clk(clk), .rst(rst),
    .acc_valid(acc_valid), .acc_set(acc_set), .acc_way(acc_way),
    .inv_valid(inv_valid), .inv_set(inv_set), .inv_way(inv_way),
    .req_valid(req_valid), .req_ready(req_ready1), .req_set(req_set),
    .vic_valid(vic_valid1), .vic_way(vic_way1), .vic_empty(vic_empty1),
    .vic_ready(vic_ready)
  );

  task automatic check(input string name, input int act, input int exp);
    cmp++;
    if (act != exp) begin
      err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Issue one request, wait for the offer; leaves the DUTs in RESP.
  task automatic do_req(input int s);
    int n;
    n = 0;
    while (!req_ready0 && n < 20) begin @(posedge clk); #1; n++; end
    check("req_ready_idle", int'(req_ready0), 1);
    req_set   = 4'(s);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!vic_valid0 && n < 20) begin @(posedge clk); #1; n++; end
    check("offer_latency", n, 2);
    check("fifo_offer_valid", int'(vic_valid1), 1);
  endtask

  task automatic do_commit();
    vic_ready = 1'b1;
    @(posedge clk); #1;
    vic_ready = 1'b0;
  endtask

  task automatic do_acc(input int s, input int w);
    acc_valid = 1'b1;
    acc_set   = 4'(s);
    acc_way   = 2'(w);
    @(posedge clk); #1;
    acc_valid = 1'b0;
  endtask

  typedef struct packed {
    int op;   // 0 = request+commit, 1 = access hit
    int set;
    int way;
    int ew0;
    int ee0;
    int ew1;
    int ee1;
  } vec_t;

  vec_t tbl [0:16];

  initial begin
    tbl = '{
      '{0, 3, 0, 0, 1, 0, 1},
      '{0, 3, 0, 1, 1, 1, 1},
      '{0, 3, 0, 2, 1, 2, 1},
      '{0, 3, 0, 3, 1, 3, 1},
      '{1, 3, 0, 0, 0, 0, 0},
      '{1, 3, 2, 0, 0, 0, 0},
      '{1, 3, 3, 0, 0, 0, 0},
      '{0, 3, 0, 1, 0, 0, 0},
      '{0, 5, 0, 0, 1, 0, 1},
      '{0, 5, 0, 1, 1, 1, 1},
      '{0, 5, 0, 2, 1, 2, 1},
      '{0, 5, 0, 3, 1, 3, 1},
      '{0, 5, 0, 0, 0, 0, 0},
      '{0, 5, 0, 1, 0, 1, 0},
      '{0, 5, 0, 2, 0, 2, 0},
      '{0, 5, 0, 3, 0, 3, 0},
      '{0, 5, 0, 0, 0, 0, 0}
    };

    repeat (2) @(posedge clk);
    #1;
    check("rst_vic_valid", int'(vic_valid0), 0);
    check("rst_set_age", int'(dut0.set_age[3]), 8'hE4);
    rst = 1'b0;
    check("ready_before_edge", int'(req_ready0), 0);
    @(posedge clk); #1;
    check("ready_after_edge", int'(req_ready0), 1);

    for (int i = 0; i < 17; i++) begin
      if (tbl[i].op == 0) begin
        do_req(tbl[i].set);
        check($sformatf("vec%0d_lru_way", i), int'(vic_way0), tbl[i].ew0);
        check($sformatf("vec%0d_lru_empty", i), int'(vic_empty0), tbl[i].ee0);
        check($sformatf("vec%0d_fifo_way", i), int'(vic_way1), tbl[i].ew1);
        check($sformatf("vec%0d_fifo_empty", i), int'(vic_empty1), tbl[i].ee1);
        do_commit();
      end else begin
        do_acc(tbl[i].set, tbl[i].way);
      end
    end

    // inv and acc on the same line in one cycle: inv wins, age untouched
    inv_valid = 1'b1; inv_set = 4'd3; inv_way = 2'd2;
    acc_valid = 1'b1; acc_set = 4'd3; acc_way = 2'd2;
    @(posedge clk); #1;
    inv_valid = 1'b0; acc_valid = 1'b0;
    check("inv_valid_bits", int'(dut0.set_valid[3]), 4'b1011);
    check("inv_age_lru", int'(dut0.set_age[3][2]), 2);
    check("inv_age_fifo", int'(dut1.set_age[3][2]), 2);
    do_req(3);
    check("inv_lru_way", int'(vic_way0), 2);
    check("inv_lru_empty", int'(vic_empty0), 1);
    check("inv_fifo_way", int'(vic_way1), 2);
    check("inv_fifo_empty", int'(vic_empty1), 1);
    do_commit();

    // Offer must stay put while accesses hit the latched set
    do_req(3);
    check("hold_lru_way0", int'(vic_way0), 0);
    check("hold_fifo_way0", int'(vic_way1), 1);
    for (int c = 0; c < 10; c++) begin
      acc_valid = 1'b1; acc_set = 4'd3; acc_way = 2'(c % 4);
      @(posedge clk); #1;
      check($sformatf("hold_lru_way_c%0d", c), int'(vic_way0), 0);
      check($sformatf("hold_fifo_way_c%0d", c), int'(vic_way1), 1);
      check($sformatf("hold_valid_c%0d", c), int'(vic_valid0), 1);
    end
    acc_valid = 1'b0;

    // Asynchronous reset in RESP
    #2 rst = 1'b1;
    #1;
    check("arst_vic_valid", int'(vic_valid0), 0);
    check("arst_vic_way", int'(vic_way1), 0);
    check("arst_req_ready", int'(req_ready0), 0);
    check("arst_valid_bits", int'(dut0.set_valid[3]), 0);
    check("arst_age", int'(dut1.set_age[3]), 8'hE4);
    check("arst_ptr", int'(dut1.set_ptr[3]), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("arst_ready_after", int'(req_ready0), 1);
    do_req(3);
    check("post_rst_way", int'(vic_way0), 0);
    check("post_rst_empty", int'(vic_empty0), 1);
    do_commit();

    // Reset during LOOKUP abandons the request without a commit
    req_set = 4'd7; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("lookup_rst_valid7", int'(dut0.set_valid[7]), 0);
    check("lookup_rst_vic_valid", int'(vic_valid0), 0);
    check("lookup_rst_ready", int'(req_ready0), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
